// File: rtl/utopia_rx_assembler_pkg.sv
// Shared ATM definitions for the Utopia receive cell assembler: cell type,
// receive FSM states, cell/header geometry and HEC constants.
package utopia_rx_assembler_pkg;

    localparam int         CELL_LEN  = 53;
    localparam int         HDR_LEN   = 5;
    localparam logic [7:0] HEC_COSET = 8'h55;
    localparam logic [7:0] HEC_POLY  = 8'h07;  // x^8 + x^2 + x + 1, x^8 implicit

    typedef logic [CELL_LEN*8-1:0] ATMCellType;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } rx_state_t;

    // One byte of MSB-first CRC-8 over HEC_POLY.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ HEC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/utopia_rx_assembler_hec_crc8.sv
// Byte-serial CRC-8 engine for the ATM header error check. clear restarts the
// sum from zero; when clear and byte_en coincide the byte starts a fresh sum.
module atm_hec_crc8
    import utopia_rx_assembler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] seed;

    assign seed = clear ? 8'h00 : crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (byte_en) begin
            crc <= crc8_step(seed, data);
        end else if (clear) begin
            crc <= 8'h00;
        end
    end

endmodule

// File: rtl/utopia_rx_assembler.sv
// Utopia level-1 receive side: collects 53-byte cells from the PHY and hands
// them to the core with valid/ready. Optional header check: UTOPIA_RX_HEC_CHECK_EN.
module utopia_rx_assembler
    import utopia_rx_assembler_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             soc,
    input  logic             clav,
    output logic             en,
    output ATMCellType       ATMCell,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] cell_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output rx_state_t        fsm_state
`ifdef UTOPIA_RX_HEC_CHECK_EN
    ,
    output logic             hec_err
`endif
);

    // Handshake: a cell is accepted on a rising edge with valid=1 and ready=1;
    // valid and ATMCell do not change while valid=1 and ready=0.

    rx_state_t  state;
    logic [5:0] idx;
    logic       xfer;
    logic       start_cell;
    logic       body_byte;
    logic       last_byte;
    logic       hec_ok;
    logic       to_hold;
    logic       hold_next;

    // en is the registered read enable, so a byte moves on every edge where it is low.
    assign xfer       = !en;
    assign start_cell = xfer && soc && (state != HOLD);
    assign body_byte  = xfer && !soc && (state == RECV);
    assign last_byte  = body_byte && (idx == 6'(CELL_LEN - 1));
    assign to_hold    = last_byte && hec_ok;
    assign hold_next  = to_hold || ((state == HOLD) && !(valid && ready));
    assign fsm_state  = state;

`ifdef UTOPIA_RX_HEC_CHECK_EN
    logic [7:0] crc;
    logic       hec_bad;

    atm_hec_crc8 u_hec (
        .clk     (clk_in),
        .rst     (reset),
        .clear   (start_cell),
        .byte_en (start_cell || (body_byte && (idx < 6'(HDR_LEN - 1)))),
        .data    (data),
        .crc     (crc)
    );

    assign hec_ok = !hec_bad;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hec_bad <= 1'b0;
            hec_err <= 1'b0;
        end else begin
            hec_err <= last_byte && hec_bad;
            if (start_cell) begin
                hec_bad <= 1'b0;
            end else if (body_byte && (idx == 6'(HDR_LEN - 1))) begin
                hec_bad <= ((crc ^ HEC_COSET) != data);
            end
        end
    end
`else
    assign hec_ok = 1'b1;
`endif

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            en       <= 1'b1;
            valid    <= 1'b0;
            ATMCell  <= '0;
            cell_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            // Back-pressure: no reads while a finished cell waits for the core.
            en <= !(clav && !hold_next);
            case (state)
                IDLE: begin
                    if (start_cell) begin
                        ATMCell[8*CELL_LEN-1 -: 8] <= data;
                        idx   <= 6'd1;
                        state <= RECV;
                    end
                end
                RECV: begin
                    if (start_cell) begin
                        drop_cnt <= drop_cnt + 1'b1;
                        ATMCell[8*CELL_LEN-1 -: 8] <= data;
                        idx <= 6'd1;
                    end else if (body_byte) begin
                        ATMCell[8*(CELL_LEN-1-int'(idx)) +: 8] <= data;
                        idx <= idx + 6'd1;
                        if (last_byte) begin
                            idx <= '0;
                            if (hec_ok) begin
                                valid <= 1'b1;
                                state <= HOLD;
                            end else begin
                                drop_cnt <= drop_cnt + 1'b1;
                                state    <= IDLE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (valid && ready) begin
                        cell_cnt <= cell_cnt + 1'b1;
                        valid    <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_utopia_rx_assembler.sv
// Bench for utopia_rx_assembler: directed scenarios plus a randomized cell
// stream, checked against an expected-cell queue and counter model.
module tb_utopia_rx_assembler;
    import utopia_rx_assembler_pkg::*;

    localparam int CW = 4;

    logic           clk_in = 1'b0;
    logic           reset;
    logic [7:0]     data;
    logic           soc;
    logic           clav;
    logic           ready;
    logic           en;
    ATMCellType     ATMCell;
    logic           valid;
    logic [CW-1:0]  cell_cnt;
    logic [CW-1:0]  drop_cnt;
    rx_state_t      fsm_state;
`ifdef UTOPIA_RX_HEC_CHECK_EN
    logic           hec_err;
`endif

    utopia_rx_assembler #(.CNT_W(CW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .data      (data),
        .soc       (soc),
        .clav      (clav),
        .en        (en),
        .ATMCell   (ATMCell),
        .valid     (valid),
        .ready     (ready),
        .cell_cnt  (cell_cnt),
        .drop_cnt  (drop_cnt),
        .fsm_state (fsm_state)
`ifdef UTOPIA_RX_HEC_CHECK_EN
        ,
        .hec_err   (hec_err)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int exp_cells = 0;
    int exp_drops = 0;
    bit drv_done;

    // stream entry: {bad_hec_last, good_last, soc, data}
    logic [10:0]  stream_q[$];
    logic [423:0] exp_q[$];

    task automatic check(input string tag, input logic [423:0] obs, input logic [423:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Header check value by polynomial long division of header*x^8 by 0x107.
    function automatic logic [7:0] ref_hec(input logic [31:0] hdr);
        logic [39:0] m;
        m = {hdr, 8'h00};
        for (int bit_i = 39; bit_i >= 8; bit_i--) begin
            if (m[bit_i]) m = m ^ (40'h107 << (bit_i - 8));
        end
        return m[7:0] ^ 8'h55;
    endfunction

    function automatic logic [423:0] rand_cell();
        logic [423:0] c;
        for (int i = 0; i < 53; i++) c[423-8*i -: 8] = 8'($urandom_range(0, 255));
        return c;
    endfunction

    task automatic add_cell(input logic [423:0] c_in, input bit bad);
        logic [423:0] c;
        c = c_in;
`ifdef UTOPIA_RX_HEC_CHECK_EN
        c[391 -: 8] = ref_hec(c[423 -: 32]) ^ {7'd0, bad};
`endif
        for (int i = 0; i < 53; i++)
            stream_q.push_back({bad && (i == 52), !bad && (i == 52), i == 0, c[423-8*i -: 8]});
        if (bad) exp_drops++;
        else exp_q.push_back(c);
    endtask

    // Truncated cell; counted as a drop only when the next soc aborts it.
    task automatic add_partial(input int n, input bit aborted_by_soc);
        for (int i = 0; i < n; i++)
            stream_q.push_back({2'b00, i == 0, 8'($urandom_range(0, 255))});
        if (aborted_by_soc) exp_drops++;
    endtask

    task automatic add_junk(input int n);
        for (int i = 0; i < n; i++) stream_q.push_back({3'b000, 8'($urandom_range(0, 255))});
    endtask

    // PHY model: offers stream bytes; a byte is consumed on each edge where en is low.
    task automatic phy_run(input int gap_at, input int gap_len, input bit rnd_clav);
        int   taken = 0;
        int   gap_left = 0;
        int   guard = 0;
        bit   gap_done = 0;
        bit   clav_prev;
        bit   pend_last = 0;
        bit   pend_bad = 0;
        logic [10:0] e;
        clav_prev = clav;
        while (stream_q.size() > 0 && guard < 5000) begin
            @(negedge clk_in);
            guard++;
            if (!clav_prev) check("en_high_without_clav", en, 1);
            if (pend_last) check("valid_1clk_after_last", valid, 1);
            if (pend_bad) check("no_valid_on_bad_hec", valid, 0);
`ifdef UTOPIA_RX_HEC_CHECK_EN
            if (pend_bad) check("hec_err_pulse", hec_err, 1);
`endif
            pend_last = 0;
            pend_bad  = 0;
            if (!gap_done && taken == gap_at) begin
                gap_left = gap_len;
                gap_done = 1;
            end
            if (gap_left > 0) begin
                clav = 1'b0;
                gap_left--;
            end else begin
                clav = rnd_clav ? ($urandom_range(0, 7) != 0) : 1'b1;
            end
            clav_prev = clav;
            e    = stream_q[0];
            data = e[7:0];
            soc  = e[8];
            if (en === 1'b0) begin
                void'(stream_q.pop_front());
                taken++;
                pend_last = e[9];
                pend_bad  = e[10];
            end
        end
        check("stream_consumed", stream_q.size(), 0);
        @(negedge clk_in);
        if (pend_last) check("valid_1clk_after_last", valid, 1);
        if (pend_bad) check("no_valid_on_bad_hec", valid, 0);
`ifdef UTOPIA_RX_HEC_CHECK_EN
        if (pend_bad) check("hec_err_pulse", hec_err, 1);
`endif
        clav = 1'b0;
        soc  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || valid !== 1'b0) && guard < 400) begin
            @(negedge clk_in);
            guard++;
        end
        check("drain_expected_cells", exp_q.size(), 0);
        @(negedge clk_in);
        check("cell_cnt", cell_cnt, exp_cells % (1 << CW));
        check("drop_cnt", drop_cnt, exp_drops % (1 << CW));
    endtask

    // Scoreboard: every accepted cell must be the next expected one.
    always @(negedge clk_in) begin
        #2;
        if (reset === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cell", valid, 0);
            end else begin
                check("cell_data", ATMCell, exp_q.pop_front());
                exp_cells++;
            end
        end
    end

    initial begin
        logic [423:0] c;
        reset = 1'b1;
        data  = 8'h00;
        soc   = 1'b0;
        clav  = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_en", en, 1);
        check("rst_valid", valid, 0);
        check("rst_cell", ATMCell, 0);
        check("rst_cell_cnt", cell_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        @(negedge clk_in);

        // Single cell with bytes 0x00..0x34.
        for (int i = 0; i < 53; i++) c[423-8*i -: 8] = 8'(i);
        add_cell(c, 0);
        phy_run(-1, 0, 0);
        wait_drain();

        // Held cell under ready=0 with clav high: stable output, no reads.
        ready = 1'b0;
        add_cell(rand_cell(), 0);
        phy_run(-1, 0, 0);
        clav = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            check("hold_valid", valid, 1);
            check("hold_cell", ATMCell, exp_q[0]);
            check("hold_en", en, 1);
            check("hold_cell_cnt", cell_cnt, exp_cells % (1 << CW));
        end
        clav  = 1'b0;
        ready = 1'b1;
        wait_drain();

        // soc at byte 30 aborts the partial cell; the next cell arrives intact.
        add_partial(30, 1);
        add_cell(rand_cell(), 0);
        phy_run(-1, 0, 0);
        wait_drain();

        // clav low for 5 clocks after 10 bytes.
        add_cell(rand_cell(), 0);
        phy_run(10, 5, 0);
        wait_drain();

        // Reset after 40 bytes, then junk without soc, then a full cell.
        add_partial(40, 0);
        phy_run(-1, 0, 0);
        reset = 1'b1;
        #1;
        check("midcell_rst_valid", valid, 0);
        check("midcell_rst_en", en, 1);
        check("midcell_rst_cell_cnt", cell_cnt, 0);
        check("midcell_rst_drop_cnt", drop_cnt, 0);
        exp_cells = 0;
        exp_drops = 0;
        @(negedge clk_in);
        reset = 1'b0;
        add_junk(7);
        add_cell(rand_cell(), 0);
        phy_run(-1, 0, 0);
        wait_drain();

        // Random mix of cells, aborted partials, junk, clav gaps and ready stalls.
        for (int k = 0; k < 22; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    add_partial($urandom_range(1, 52), 1);
                    add_cell(rand_cell(), 0);
                end
                1: begin
                    add_junk($urandom_range(1, 5));
                    add_cell(rand_cell(), 0);
                end
                default: add_cell(rand_cell(), 0);
            endcase
        end
        drv_done = 1'b0;
        fork
            begin
                phy_run(-1, 0, 1);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(negedge clk_in);
                    ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready = 1'b1;
        wait_drain();

`ifdef UTOPIA_RX_HEC_CHECK_EN
        // Zero header: HEC 0x55 is delivered, HEC 0x54 is dropped with hec_err.
        c = rand_cell();
        c[423 -: 32] = 32'h0;
        add_cell(c, 0);
        add_cell(c, 1);
        phy_run(-1, 0, 0);
        wait_drain();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", fails, -1);
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
